// File: rtl/sccb_target.sv
// SCCB target: oversamples SIO_C/SIO_D on XCLK, decodes 3-phase/2-phase writes and 2-phase reads into an 8-bit register file.
// Optional macro SCCB_TARGET_ACK_EN: drive SIO_D low during the X bit of matched ID, SUBADDR and WDATA phases.
module sccb_target #(
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter int         REG_DEPTH   = 256,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       XCLK,
  input  logic       RST,
  input  logic       SIO_C,
  inout  wire        SIO_D,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

`ifdef SCCB_TARGET_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, ID, ID_X, SUBADDR, SUB_X, WDATA, WDATA_X, RDATA, RDATA_X, IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sc_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   sc_prev;
  logic                   sd_prev;
  logic [3:0]             bit_cnt;
  logic [7:0]             shreg;
  logic [AW-1:0]          ptr;
  logic                   is_read;
  logic                   drive_low;
  logic [7:0]             regs [REG_DEPTH];

  logic          sc;
  logic          sd;
  logic          sc_rise;
  logic          sc_fall;
  logic          start_cond;
  logic          stop_cond;
  logic [7:0]    in_byte;
  logic [AW-1:0] ptr_inc;

  assign sc         = sc_sync[SYNC_STAGES-1];
  assign sd         = sd_sync[SYNC_STAGES-1];
  assign sc_rise    = sc & ~sc_prev;
  assign sc_fall    = ~sc & sc_prev;
  assign start_cond = sc & sc_prev & sd_prev & ~sd;
  assign stop_cond  = sc & sc_prev & ~sd_prev & sd;
  assign in_byte    = {shreg[6:0], sd};
  assign ptr_inc    = (ptr == AW'(REG_DEPTH - 1)) ? '0 : ptr + 1'b1;

  // Open-drain: only ever pull low, the external pull-up provides the 1.
  assign SIO_D = drive_low ? 1'b0 : 1'bz;

  // Bus conditions take priority over the phase FSM; every phase is 8 bits on
  // sc_rise followed by an X bit whose closing sc_fall advances the state.
  always_ff @(posedge XCLK) begin
    if (RST) begin
      sc_sync   <= '1;
      sd_sync   <= '1;
      sc_prev   <= 1'b1;
      sd_prev   <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      is_read   <= 1'b0;
      drive_low <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
    end else begin
      sc_sync  <= {sc_sync[SYNC_STAGES-2:0], SIO_C};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], SIO_D};
      sc_prev  <= sc;
      sd_prev  <= sd;
      wr_valid <= 1'b0;
      if (start_cond) begin
        state     <= ID;
        bit_cnt   <= '0;
        busy      <= 1'b0;
        drive_low <= 1'b0;
      end else if (stop_cond) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        busy      <= 1'b0;
        drive_low <= 1'b0;
      end else begin
        case (state)
          ID, SUBADDR, WDATA: begin
            if (sc_rise) begin
              shreg   <= in_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                case (state)
                  ID: begin
                    if (in_byte[7:1] == DEV_ID[7:1]) begin
                      state   <= ID_X;
                      busy    <= 1'b1;
                      is_read <= in_byte[0];
                    end else begin
                      state <= IGNORE;
                    end
                  end
                  SUBADDR: begin
                    ptr   <= AW'(in_byte % REG_DEPTH);
                    state <= SUB_X;
                  end
                  default: begin
                    regs[ptr] <= in_byte;
                    wr_valid  <= 1'b1;
                    wr_addr   <= 8'(ptr);
                    wr_data   <= in_byte;
                    ptr       <= ptr_inc;
                    state     <= WDATA_X;
                  end
                endcase
              end
            end
          end
          ID_X, SUB_X, WDATA_X: begin
            if (sc_rise) begin
              bit_cnt <= 4'd1;
            end else if (sc_fall) begin
              if (bit_cnt == 4'd0) begin
                drive_low <= ACK_EN;
              end else begin
                bit_cnt   <= '0;
                drive_low <= 1'b0;
                if (state == ID_X && is_read) begin
                  shreg     <= regs[ptr];
                  drive_low <= ~regs[ptr][7];
                  state     <= RDATA;
                end else if (state == ID_X) begin
                  state <= SUBADDR;
                end else begin
                  state <= WDATA;
                end
              end
            end
          end
          // bit_cnt counts bits already sampled by the initiator; after the
          // 8th the following fall releases the line for the NA bit.
          RDATA: begin
            if (sc_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (sc_fall) begin
              if (bit_cnt == 4'd8) begin
                drive_low <= 1'b0;
                bit_cnt   <= '0;
                state     <= RDATA_X;
              end else begin
                shreg     <= {shreg[6:0], 1'b0};
                drive_low <= ~shreg[6];
              end
            end
          end
          RDATA_X: begin
            if (sc_rise) begin
              bit_cnt <= 4'd1;
            end else if (sc_fall && bit_cnt == 4'd1) begin
              bit_cnt <= '0;
              state   <= IGNORE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// Randomised bench for sccb_target: bit-bangs SCCB on an open-drain bus and
// compares writes and read-back bytes against a register-array model.
module tb_sccb_target;

  localparam int Q = 8;

  logic       xclk = 1'b0;
  logic       rst;
  logic       sio_c;
  logic       tb_low;
  wire        sio_d;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  model_mem [256];
  logic [15:0] wq [$];
  logic [15:0] exp_q [$];
  logic        prev_wv = 1'b0;
  logic        long_pulse = 1'b0;

  assign sio_d = tb_low ? 1'b0 : 1'bz;
  pullup (sio_d);

  always #5 xclk = ~xclk;

  sccb_target dut (
    .XCLK     (xclk),
    .RST      (rst),
    .SIO_C    (sio_c),
    .SIO_D    (sio_d),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  // Record every write strobe and flag any strobe longer than one cycle.
  always @(negedge xclk) begin
    if (wr_valid) wq.push_back({wr_addr, wr_data});
    if (wr_valid && prev_wv) long_pulse <= 1'b1;
    prev_wv <= wr_valid;
  end

  task automatic wait_q(input int n);
    repeat (n) @(negedge xclk);
  endtask

  task automatic send_start();
    tb_low = 1'b0;
    wait_q(Q);
    sio_c = 1'b1;
    wait_q(2 * Q);
    tb_low = 1'b1;
    wait_q(2 * Q);
    sio_c = 1'b0;
    wait_q(Q);
  endtask

  task automatic send_stop();
    tb_low = 1'b1;
    wait_q(Q);
    sio_c = 1'b1;
    wait_q(2 * Q);
    tb_low = 1'b0;
    wait_q(2 * Q);
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    tb_low = ~b;
    wait_q(Q);
    sio_c = 1'b1;
    wait_q(Q);
    seen = sio_d;
    wait_q(Q);
    sio_c = 1'b0;
    wait_q(Q);
  endtask

  // Eight bits plus the released X bit; any disagreement on the wire is an error.
  task automatic send_byte(input logic [7:0] b, inout int err);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(b[i], s);
      if (s !== b[i]) err++;
    end
    clock_bit(1'b1, s);
    if (s !== 1'b1) err++;
  endtask

  task automatic sccb_write(input logic [7:0] id, input logic [7:0] addr, input int n,
                            input logic [7:0] d [4], output logic busy_mid, output int err);
    err = 0;
    send_start();
    send_byte(id, err);
    busy_mid = busy;
    send_byte(addr, err);
    for (int i = 0; i < n; i++) send_byte(d[i], err);
    send_stop();
  endtask

  task automatic sccb_read(input logic [7:0] id, output logic [7:0] val, output logic na,
                           output int err);
    logic s;
    err = 0;
    val = '0;
    send_start();
    send_byte(id, err);
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      val = {val[6:0], s};
    end
    clock_bit(1'b1, na);
    send_stop();
  endtask

  // Model: consecutive bytes land at addr, addr+1, ... modulo 256.
  task automatic model_write(input logic [7:0] addr, input int n, input logic [7:0] d [4]);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'((int'(addr) + i) % 256), d[i]});
      model_mem[(int'(addr) + i) % 256] = d[i];
    end
  endtask

  task automatic clear_log();
    wait_q(2);
    wq.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_q(4);
    checks++; if (sio_d !== 1'b1)   begin fails++; $display("[TB] FAIL reset_sio_d: got %b expected 1", sio_d); end
    checks++; if (busy !== 1'b0)    begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (wr_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_wr_valid: got %b expected 0", wr_valid); end
    checks++; if ({wr_addr, wr_data} !== 16'h0) begin fails++; $display("[TB] FAIL reset_wr_bus: got %h expected 0000", {wr_addr, wr_data}); end
    rst = 1'b0;
    wait_q(4);
  endtask

  task automatic test_three_phase();
    logic [7:0] d [4];
    logic bm;
    int err;
    clear_log();
    d = '{8'h80, 8'h00, 8'h00, 8'h00};
    sccb_write(8'h42, 8'h12, 1, d, bm, err);
    model_write(8'h12, 1, d);
    wait_q(4);
    checks++; if (bm !== 1'b1)   begin fails++; $display("[TB] FAIL 3ph_busy_mid: got %b expected 1", bm); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL 3ph_busy_after_stop: got %b expected 0", busy); end
    checks++; if (err != 0)      begin fails++; $display("[TB] FAIL 3ph_bus_echo: got %0d errors expected 0", err); end
    checks++;
    if (wq.size() != 1) begin
      fails++; $display("[TB] FAIL 3ph_write_count: got %0d expected 1", wq.size());
    end else if (wq[0] !== 16'h1280) begin
      fails++; $display("[TB] FAIL 3ph_write: got %h expected 1280", wq[0]);
    end
    checks++; if (long_pulse !== 1'b0) begin fails++; $display("[TB] FAIL 3ph_pulse_width: got long pulse expected single cycle"); end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] d [4];
    logic bm;
    int err;
    clear_log();
    d = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    sccb_write(8'h42, 8'hFF, 2, d, bm, err);
    model_write(8'hFF, 2, d);
    wait_q(4);
    checks++; if (err != 0) begin fails++; $display("[TB] FAIL burst_bus_echo: got %0d errors expected 0", err); end
    checks++;
    if (wq.size() != exp_q.size()) begin
      fails++; $display("[TB] FAIL burst_count: got %0d expected %0d", wq.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (wq[i] !== exp_q[i]) begin fails++; $display("[TB] FAIL burst_write%0d: got %h expected %h", i, wq[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_read();
    logic [7:0] d [4];
    logic [7:0] v;
    logic bm, na;
    int err, rerr;
    clear_log();
    d = '{8'h00, 8'h00, 8'h00, 8'h00};
    sccb_write(8'h42, 8'h12, 0, d, bm, err);
    sccb_read(8'h43, v, na, rerr);
    checks++; if (v !== model_mem[8'h12]) begin fails++; $display("[TB] FAIL read_data: got %h expected %h", v, model_mem[8'h12]); end
    checks++; if (na !== 1'b1) begin fails++; $display("[TB] FAIL read_na_released: got %b expected 1", na); end
    checks++; if (err + rerr != 0) begin fails++; $display("[TB] FAIL read_bus_echo: got %0d errors expected 0", err + rerr); end
    sccb_read(8'h43, v, na, rerr);
    checks++; if (v !== model_mem[8'h12]) begin fails++; $display("[TB] FAIL read_ptr_kept: got %h expected %h", v, model_mem[8'h12]); end
    checks++; if (wq.size() != 0) begin fails++; $display("[TB] FAIL read_no_write: got %0d writes expected 0", wq.size()); end
  endtask

  task automatic test_wrong_id();
    logic [7:0] d [4];
    logic bm;
    int err;
    clear_log();
    d = '{8'h55, 8'h00, 8'h00, 8'h00};
    sccb_write(8'h60, 8'h12, 1, d, bm, err);
    wait_q(4);
    checks++; if (bm !== 1'b0) begin fails++; $display("[TB] FAIL wrongid_busy: got %b expected 0", bm); end
    checks++; if (err != 0) begin fails++; $display("[TB] FAIL wrongid_sio_d: got %0d pulled bits expected 0", err); end
    checks++; if (wq.size() != 0) begin fails++; $display("[TB] FAIL wrongid_no_write: got %0d writes expected 0", wq.size()); end
  endtask

  task automatic test_abort_stop();
    logic [7:0] d [4];
    logic [7:0] v;
    logic bm, na, s;
    int err;
    d = '{8'($urandom), 8'($urandom), 8'h00, 8'h00};
    sccb_write(8'h42, 8'h30, 2, d, bm, err);
    model_write(8'h30, 2, d);
    clear_log();
    err = 0;
    send_start();
    send_byte(8'h42, err);
    send_byte(8'h30, err);
    for (int i = 0; i < 4; i++) clock_bit(i[0], s);
    send_stop();
    wait_q(4);
    checks++; if (wq.size() != 0) begin fails++; $display("[TB] FAIL abort_stop_no_write: got %0d writes expected 0", wq.size()); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_stop_busy: got %b expected 0", busy); end
    sccb_read(8'h43, v, na, err);
    checks++; if (v !== model_mem[8'h30]) begin fails++; $display("[TB] FAIL abort_stop_ptr: got %h expected %h", v, model_mem[8'h30]); end
  endtask

  task automatic test_abort_restart();
    logic [7:0] d [4];
    logic [7:0] v;
    logic bm, na, s;
    int err;
    d = '{8'($urandom), 8'($urandom), 8'h00, 8'h00};
    sccb_write(8'h42, 8'h40, 2, d, bm, err);
    model_write(8'h40, 2, d);
    clear_log();
    err = 0;
    send_start();
    send_byte(8'h42, err);
    send_byte(8'h40, err);
    send_byte(8'h3C, err);
    for (int i = 0; i < 5; i++) clock_bit(1'b0, s);
    model_mem[8'h40] = 8'h3C;
    exp_q.push_back(16'h403C);
    sccb_read(8'h43, v, na, err);
    wait_q(4);
    checks++;
    if (wq.size() != 1) begin
      fails++; $display("[TB] FAIL restart_write_count: got %0d expected 1", wq.size());
    end else if (wq[0] !== exp_q[0]) begin
      fails++; $display("[TB] FAIL restart_write: got %h expected %h", wq[0], exp_q[0]);
    end
    checks++; if (v !== model_mem[8'h41]) begin fails++; $display("[TB] FAIL restart_read: got %h expected %h", v, model_mem[8'h41]); end
  endtask

  task automatic test_rst_mid_read();
    logic [7:0] d [4];
    logic [7:0] v;
    logic bm, na, s;
    int err;
    d = '{8'($urandom) & 8'hF7, 8'h00, 8'h00, 8'h00};
    sccb_write(8'h42, 8'h50, 1, d, bm, err);
    model_write(8'h50, 1, d);
    sccb_write(8'h42, 8'h50, 0, d, bm, err);
    clear_log();
    err = 0;
    v = '0;
    send_start();
    send_byte(8'h43, err);
    for (int i = 0; i < 4; i++) begin
      clock_bit(1'b1, s);
      v = {v[6:0], s};
    end
    checks++; if (v[3:0] !== d[0][7:4]) begin fails++; $display("[TB] FAIL rst_read_hi_nibble: got %h expected %h", v[3:0], d[0][7:4]); end
    checks++; if (sio_d !== 1'b0) begin fails++; $display("[TB] FAIL rst_read_bit3_driven: got %b expected 0", sio_d); end
    rst = 1'b1;
    @(posedge xclk);
    @(negedge xclk);
    checks++; if (sio_d !== 1'b1) begin fails++; $display("[TB] FAIL rst_read_release: got %b expected 1", sio_d); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_read_busy: got %b expected 0", busy); end
    wait_q(2);
    rst = 1'b0;
    wait_q(2);
    sio_c = 1'b1;
    wait_q(2 * Q);
    sccb_write(8'h42, 8'h50, 0, d, bm, err);
    sccb_read(8'h43, v, na, err);
    checks++; if (v !== model_mem[8'h50]) begin fails++; $display("[TB] FAIL rst_read_recover: got %h expected %h", v, model_mem[8'h50]); end
    checks++; if (wq.size() != 0) begin fails++; $display("[TB] FAIL rst_read_no_write: got %0d writes expected 0", wq.size()); end
  endtask

  task automatic test_random_back_to_back();
    logic [7:0] d [4];
    logic [7:0] addr, ra, v;
    logic bm, na;
    int n, err, rerr;
    for (int it = 0; it < 5; it++) begin
      clear_log();
      addr = 8'($urandom_range(0, 255));
      n    = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      sccb_write(8'h42, addr, n, d, bm, err);
      model_write(addr, n, d);
      wait_q(4);
      checks++;
      if (wq.size() != exp_q.size()) begin
        fails++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", it, wq.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (wq[i] !== exp_q[i]) begin fails++; $display("[TB] FAIL rand%0d_write%0d: got %h expected %h", it, i, wq[i], exp_q[i]); end
        end
      end
      ra = 8'((int'(addr) + $urandom_range(0, n - 1)) % 256);
      sccb_write(8'h42, ra, 0, d, bm, rerr);
      sccb_read(8'h43, v, na, rerr);
      checks++; if (v !== model_mem[ra]) begin fails++; $display("[TB] FAIL rand%0d_readback: got %h expected %h at %h", it, v, model_mem[ra], ra); end
      checks++; if (err != 0) begin fails++; $display("[TB] FAIL rand%0d_bus_echo: got %0d errors expected 0", it, err); end
    end
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    sio_c  = 1'b1;
    tb_low = 1'b0;
    test_reset();
    test_three_phase();
    test_burst_wrap();
    test_read();
    test_wrong_id();
    test_abort_stop();
    test_abort_restart();
    test_rst_mid_read();
    test_random_back_to_back();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
